// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters with IF->ID prediction tracking.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor_bht #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bp_enable,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  input  logic        advance,
  input  logic        flush,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  output logic        mispredict,
  output logic        ready,
  output logic [31:0] bp_total,
  output logic [31:0] bp_correct,
  output logic [31:0] bp_wrong
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] init_idx;
  logic [1:0]            tbl [ENTRIES];

  logic                  pend_valid;
  logic                  pend_pred;
  logic [31:0]           pend_pc;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            update_ctr;
  logic [1:0]            next_ctr;
  logic                  recorded_pred;
  logic                  update_fire;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  assign ready      = (state == ST_RUN);

  always_comb begin
    update_ctr    = tbl[update_idx];
    predict_taken = bp_enable & ready & tbl[lookup_idx][1];
    // A matching in-flight IF->ID entry holds the prediction that was actually used.
    if (pend_valid && (pend_pc == update_pc))
      recorded_pred = pend_pred;
    else
      recorded_pred = bp_enable & update_ctr[1];
    update_fire = update_valid & ready;
    mispredict  = update_fire & (recorded_pred != update_taken);
  end

  always_comb begin
    next_ctr = update_ctr;
    if (update_taken) begin
      if (update_ctr != 2'b11) next_ctr = update_ctr + 2'b01;
    end else begin
      if (update_ctr != 2'b00) next_ctr = update_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == '1) state <= ST_RUN;
    end
  end

  // The table has no reset of its own; INIT sweeps every entry after rst falls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        tbl[init_idx] <= INIT_STATE;
      else if (update_valid)
        tbl[update_idx] <= next_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pred  <= 1'b0;
      pend_pc    <= '0;
    end else if (flush) begin
      pend_valid <= 1'b0;
    end else if (advance) begin
      pend_valid <= 1'b1;
      pend_pred  <= predict_taken;
      pend_pc    <= lookup_pc;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bp_total   <= '0;
      bp_correct <= '0;
      bp_wrong   <= '0;
    end else if (update_fire) begin
      bp_total <= bp_total + 32'd1;
      if (recorded_pred == update_taken)
        bp_correct <= bp_correct + 32'd1;
      else
        bp_wrong <= bp_wrong + 32'd1;
    end
  end
`else
  assign bp_total   = '0;
  assign bp_correct = '0;
  assign bp_wrong   = '0;
`endif

endmodule
